pipe_con_unit: RTL and testbench
================================

# pipe_con_unit

Parametrised, pipelined successor to the combinational control unit. Decodes the 6-bit opcode/funct of the instruction in Decode, then carries the control bundle through Execute, Memory and Writeback registers, inserting bubbles on flush or stall. Adds a multi-cycle multiply mode that holds Execute for a configurable number of cycles. It sits between the IF/ID register and the datapath pipeline registers, alongside the external hazard unit.

## Interface
- ALUC_W, 3: ALUControl width (≥3); codes are zero-extended.
- MUL_LAT, 4: cycles a `mult` occupies Execute (1..15).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- op_d  in  6  opcode of the Decode instruction
- funct_d  in  6  funct field of the Decode instruction
- shamt_d  in  5  shift amount; registered into E unchanged
- valid_d  in  1  the Decode instruction is real (0 = bubble)
- stall_in  in  1  hazard unit requests a load-use stall
- flush_e  in  1  branch/jump taken; kill the Decode instruction
- imm_src_d  out  2  immediate-extend select (combinational, Decode)
- jump_d  out  1  `j` in Decode (combinational, gated by valid_d)
- illegal_d  out  1  unknown opcode/funct with valid_d=1 (combinational)
- stall_d  out  1  hold PC and IF/ID this cycle
- reg_write_e, alu_src_e, dst_src_e, opt_e  out  1 each  Execute controls
- alu_control_e  out  ALUC_W  Execute ALU operation
- shamt_e  out  5  Execute shift amount
- mul_busy_e  out  1  multiply in progress in Execute
- reg_write_m, mem_write_m, result_src_m  out  1 each  Memory controls
- reg_write_w, result_src_w  out  1 each  Writeback controls

## Operation
- Decode (combinational, all zeros when valid_d=0):
  - R-type op 000000, funct: add 100000→ALUC 010; sub 100010→110; and 100100→000; or 100101→001; slt 101010→111; mult 011000→010 with opt=1. reg_write=1, dst_src=1.
  - lw 100011: reg_write, alu_src, result_src, ALUC 010, imm_src 00.
  - sw 101011: mem_write, alu_src, ALUC 010, imm_src 01.
  - addi 001000: reg_write, alu_src, ALUC 010, imm_src 00.
  - beq 000100: ALUC 110, imm_src 10.
  - j 000010: jump_d=1, imm_src 11, no writes.
  - Anything else: illegal_d=1; bundle forced to a bubble.
- Bubble = every control bit 0, ALUC 0, shamt 0.
- Multiply FSM, states IDLE/BUSY, down-counter cnt (4 bits):
  - IDLE: when an opt=1 bundle loads into E and MUL_LAT>1, go BUSY with cnt=MUL_LAT-1.
  - BUSY: decrement cnt each cycle; at cnt=1 return to IDLE. E holds its bundle; M loads a bubble.
  - mul_busy_e=1 exactly in BUSY.
- E-register load priority, per clock: hold (BUSY) > flush_e (bubble) > stall_in (bubble) > decoded bundle.
- stall_d = stall_in OR mul_busy_e. flush_e does not assert stall_d.
- flush_e during BUSY: E keeps the multiply (it is older); the flush is the upstream's responsibility.
- M loads E's bundle each cycle, or a bubble in BUSY; W always loads M.

## Timing
- rst asserted: every registered output 0, FSM IDLE, cnt 0, stall_d 0 (unless stall_in), asynchronously.
- Decode outputs are valid in the same cycle; E outputs appear 1 cycle after Decode, M after 2, W after 3.
- A multiply with MUL_LAT=N holds E for N cycles and asserts stall_d for N-1 cycles. Its bundle reaches M N cycles after entering E.
- MUL_LAT=1: no BUSY state and no stall; it behaves like add.
- Back-to-back multiplies: the second enters E on the cycle BUSY exits, then starts its own BUSY.
- Reset mid-BUSY: return to IDLE immediately; the multiply is discarded.

## Test plan
- Reset, then add (000000/100000) valid: cycle+1 reg_write_e=1, alu_control_e=010, dst_src_e=1; cycle+3 reg_write_w=1.
- lw then sw: result_src_m=1 on the lw's M cycle; mem_write_m=1 one cycle later; imm_src_d=00 then 01.
- mult with MUL_LAT=4: mul_busy_e=1 and stall_d=1 for 3 cycles; M sees 3 bubbles; opt bundle in M at cycle 4.
- flush_e=1 with addi in Decode: all E outputs 0 next cycle; stall_in=1 gives the same bubble plus stall_d=1.
- op 111111, valid_d=1: illegal_d=1 and no write bits set in any stage.
- Assert rst during BUSY cycle 2: all outputs 0 immediately; after release, an add flows normally.

Source files
------------

// File: rtl/pipe_con_unit.sv
// Pipelined control unit: decodes opcode/funct in Decode and carries the control
// bundle through E/M/W registers, with bubbles on flush/stall and a multi-cycle multiply hold.
module pipe_con_unit #(
  parameter int ALUC_W  = 3,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        op_d,
  input  logic [5:0]        funct_d,
  input  logic [4:0]        shamt_d,
  input  logic              valid_d,
  input  logic              stall_in,
  input  logic              flush_e,
  output logic [1:0]        imm_src_d,
  output logic              jump_d,
  output logic              illegal_d,
  output logic              stall_d,
  output logic              reg_write_e,
  output logic              alu_src_e,
  output logic              dst_src_e,
  output logic              opt_e,
  output logic [ALUC_W-1:0] alu_control_e,
  output logic [4:0]        shamt_e,
  output logic              mul_busy_e,
  output logic              reg_write_m,
  output logic              mem_write_m,
  output logic              result_src_m,
  output logic              reg_write_w,
  output logic              result_src_w
);

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       dst_src;
    logic       opt;
    logic       mem_write;
    logic       result_src;
    logic [2:0] aluc;
  } ctrl_t;

  typedef struct packed {
    ctrl_t      ctrl;
    logic [1:0] imm_src;
    logic       jump;
    logic       illegal;
  } dec_t;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);
  localparam bit         MUL_MULTI = (MUL_LAT > 1);

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d = '0;
    case (op)
      6'b000000: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.dst_src   = 1'b1;
        case (funct)
          6'b100000: d.ctrl.aluc = 3'b010;
          6'b100010: d.ctrl.aluc = 3'b110;
          6'b100100: d.ctrl.aluc = 3'b000;
          6'b100101: d.ctrl.aluc = 3'b001;
          6'b101010: d.ctrl.aluc = 3'b111;
          6'b011000: begin
            d.ctrl.aluc = 3'b010;
            d.ctrl.opt  = 1'b1;
          end
          default: begin
            d         = '0;
            d.illegal = 1'b1;
          end
        endcase
      end
      6'b100011: begin
        d.ctrl.reg_write  = 1'b1;
        d.ctrl.alu_src    = 1'b1;
        d.ctrl.result_src = 1'b1;
        d.ctrl.aluc       = 3'b010;
        d.imm_src         = 2'b00;
      end
      6'b101011: begin
        d.ctrl.mem_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.aluc      = 3'b010;
        d.imm_src        = 2'b01;
      end
      6'b001000: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_src   = 1'b1;
        d.ctrl.aluc      = 3'b010;
        d.imm_src        = 2'b00;
      end
      6'b000100: begin
        d.ctrl.aluc = 3'b110;
        d.imm_src   = 2'b10;
      end
      6'b000010: begin
        d.jump    = 1'b1;
        d.imm_src = 2'b11;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  dec_t       dec_s;
  ctrl_t      bundle_s;
  logic [4:0] shamt_s;
  logic       legal_s;
  logic       load_s;
  ctrl_t      e_ctrl_s;
  logic [4:0] e_shamt_s;
  state_t     state_s;
  logic [3:0] cnt_s;

  ctrl_t      e_ctrl_r;
  logic [4:0] e_shamt_r;
  logic       m_reg_write_r;
  logic       m_mem_write_r;
  logic       m_result_src_r;
  logic       w_reg_write_r;
  logic       w_result_src_r;
  state_t     state_r;
  logic [3:0] cnt_r;

  // Decode stage: everything is gated by valid_d; illegal encodings become a bubble
  always_comb begin
    dec_s     = decode(op_d, funct_d);
    legal_s   = valid_d & ~dec_s.illegal;
    bundle_s  = '0;
    shamt_s   = 5'd0;
    imm_src_d = 2'b00;
    jump_d    = 1'b0;
    illegal_d = 1'b0;
    if (valid_d) begin
      imm_src_d = dec_s.imm_src;
      jump_d    = dec_s.jump;
      illegal_d = dec_s.illegal;
    end else begin
      imm_src_d = 2'b00;
    end
    if (legal_s) begin
      bundle_s = dec_s.ctrl;
      shamt_s  = shamt_d;
    end else begin
      bundle_s = '0;
    end
  end

  assign mul_busy_e = (state_r == BUSY);
  assign stall_d    = stall_in | mul_busy_e;
  assign load_s     = (state_r == IDLE) & ~flush_e & ~stall_in;

  // E-register next value: hold while busy, then flush, then stall, then decoded bundle
  always_comb begin
    e_ctrl_s  = '0;
    e_shamt_s = 5'd0;
    if (mul_busy_e) begin
      e_ctrl_s  = e_ctrl_r;
      e_shamt_s = e_shamt_r;
    end else if (load_s) begin
      e_ctrl_s  = bundle_s;
      e_shamt_s = shamt_s;
    end else begin
      e_ctrl_s  = '0;
    end
  end

  // Multiply FSM next state: cnt counts the remaining hold cycles down to 1
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (load_s && bundle_s.opt && MUL_MULTI) begin
          state_s = BUSY;
          cnt_s   = MUL_LAT_C - 4'd1;
        end else begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end
      end
      BUSY: begin
        if (cnt_r <= 4'd1) begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end else begin
          state_s = BUSY;
          cnt_s   = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Pipeline and FSM registers; M takes a bubble while the multiply holds E
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_ctrl_r       <= '0;
      e_shamt_r      <= 5'd0;
      m_reg_write_r  <= 1'b0;
      m_mem_write_r  <= 1'b0;
      m_result_src_r <= 1'b0;
      w_reg_write_r  <= 1'b0;
      w_result_src_r <= 1'b0;
      state_r        <= IDLE;
      cnt_r          <= 4'd0;
    end else begin
      e_ctrl_r       <= e_ctrl_s;
      e_shamt_r      <= e_shamt_s;
      m_reg_write_r  <= mul_busy_e ? 1'b0 : e_ctrl_r.reg_write;
      m_mem_write_r  <= mul_busy_e ? 1'b0 : e_ctrl_r.mem_write;
      m_result_src_r <= mul_busy_e ? 1'b0 : e_ctrl_r.result_src;
      w_reg_write_r  <= m_reg_write_r;
      w_result_src_r <= m_result_src_r;
      state_r        <= state_s;
      cnt_r          <= cnt_s;
    end
  end

  assign reg_write_e   = e_ctrl_r.reg_write;
  assign alu_src_e     = e_ctrl_r.alu_src;
  assign dst_src_e     = e_ctrl_r.dst_src;
  assign opt_e         = e_ctrl_r.opt;
  assign alu_control_e = ALUC_W'(e_ctrl_r.aluc);
  assign shamt_e       = e_shamt_r;
  assign reg_write_m   = m_reg_write_r;
  assign mem_write_m   = m_mem_write_r;
  assign result_src_m  = m_result_src_r;
  assign reg_write_w   = w_reg_write_r;
  assign result_src_w  = w_result_src_r;

endmodule

// File: tb/tb_pipe_con_unit.sv
// Directed bench for pipe_con_unit: a vector table for single-cycle decode/E behaviour
// plus hand-written sequences for pipeline flow, multiply hold and reset mid-multiply.
module tb_pipe_con_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] op_d = 6'd0;
  logic [5:0] funct_d = 6'd0;
  logic [4:0] shamt_d = 5'd0;
  logic       valid_d = 1'b0;
  logic       stall_in = 1'b0;
  logic       flush_e = 1'b0;
  logic [1:0] imm_src_d;
  logic       jump_d, illegal_d, stall_d;
  logic       reg_write_e, alu_src_e, dst_src_e, opt_e;
  logic [2:0] alu_control_e;
  logic [4:0] shamt_e;
  logic       mul_busy_e;
  logic       reg_write_m, mem_write_m, result_src_m;
  logic       reg_write_w, result_src_w;

  pipe_con_unit #(.ALUC_W(3), .MUL_LAT(4)) dut (
    .clk(clk), .rst(rst), .op_d(op_d), .funct_d(funct_d), .shamt_d(shamt_d),
    .valid_d(valid_d), .stall_in(stall_in), .flush_e(flush_e),
    .imm_src_d(imm_src_d), .jump_d(jump_d), .illegal_d(illegal_d), .stall_d(stall_d),
    .reg_write_e(reg_write_e), .alu_src_e(alu_src_e), .dst_src_e(dst_src_e), .opt_e(opt_e),
    .alu_control_e(alu_control_e), .shamt_e(shamt_e), .mul_busy_e(mul_busy_e),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
    .reg_write_w(reg_write_w), .result_src_w(result_src_w)
  );

  always #5 clk = ~clk;

  // {imm_src, jump, illegal, stall_d}
  wire [4:0]  dec_obs = {imm_src_d, jump_d, illegal_d, stall_d};
  // {reg_write, alu_src, dst_src, opt, alu_control, shamt}
  wire [11:0] e_obs   = {reg_write_e, alu_src_e, dst_src_e, opt_e, alu_control_e, shamt_e};
  // {reg_write_m, mem_write_m, result_src_m, reg_write_w, result_src_w}
  wire [4:0]  mw_obs  = {reg_write_m, mem_write_m, result_src_m, reg_write_w, result_src_w};
  wire [22:0] all_obs = {dec_obs, e_obs, mw_obs, mul_busy_e};

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] shamt;
    logic       valid;
    logic       stall;
    logic       flush;
    logic [4:0] exp_dec;
    logic [11:0] exp_e;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic v, input logic st, input logic fl);
    op_d = op; funct_d = fn; shamt_d = sh; valid_d = v; stall_in = st; flush_e = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vq.push_back('{"add",       6'b000000, 6'b100000, 5'd3,  1'b1, 1'b0, 1'b0, 5'b00000, 12'b1010_010_00011});
    vq.push_back('{"sub",       6'b000000, 6'b100010, 5'd0,  1'b1, 1'b0, 1'b0, 5'b00000, 12'b1010_110_00000});
    vq.push_back('{"and",       6'b000000, 6'b100100, 5'd31, 1'b1, 1'b0, 1'b0, 5'b00000, 12'b1010_000_11111});
    vq.push_back('{"or",        6'b000000, 6'b100101, 5'd0,  1'b1, 1'b0, 1'b0, 5'b00000, 12'b1010_001_00000});
    vq.push_back('{"slt",       6'b000000, 6'b101010, 5'd0,  1'b1, 1'b0, 1'b0, 5'b00000, 12'b1010_111_00000});
    vq.push_back('{"lw",        6'b100011, 6'b000000, 5'd0,  1'b1, 1'b0, 1'b0, 5'b00000, 12'b1100_010_00000});
    vq.push_back('{"sw",        6'b101011, 6'b000000, 5'd0,  1'b1, 1'b0, 1'b0, 5'b01000, 12'b0100_010_00000});
    vq.push_back('{"addi",      6'b001000, 6'b000000, 5'd0,  1'b1, 1'b0, 1'b0, 5'b00000, 12'b1100_010_00000});
    vq.push_back('{"beq",       6'b000100, 6'b000000, 5'd0,  1'b1, 1'b0, 1'b0, 5'b10000, 12'b0000_110_00000});
    vq.push_back('{"j",         6'b000010, 6'b000000, 5'd0,  1'b1, 1'b0, 1'b0, 5'b11100, 12'b0000_000_00000});
    vq.push_back('{"ill_op",    6'b111111, 6'b000000, 5'd7,  1'b1, 1'b0, 1'b0, 5'b00010, 12'b0000_000_00000});
    vq.push_back('{"ill_funct", 6'b000000, 6'b000001, 5'd0,  1'b1, 1'b0, 1'b0, 5'b00010, 12'b0000_000_00000});
    vq.push_back('{"ill_nv",    6'b111111, 6'b000000, 5'd0,  1'b0, 1'b0, 1'b0, 5'b00000, 12'b0000_000_00000});
    vq.push_back('{"add_nv",    6'b000000, 6'b100000, 5'd3,  1'b0, 1'b0, 1'b0, 5'b00000, 12'b0000_000_00000});
    vq.push_back('{"j_nv",      6'b000010, 6'b000000, 5'd5,  1'b0, 1'b0, 1'b0, 5'b00000, 12'b0000_000_00000});
    vq.push_back('{"add_flush", 6'b000000, 6'b100000, 5'd3,  1'b1, 1'b0, 1'b1, 5'b00000, 12'b0000_000_00000});
    vq.push_back('{"addi_fl",   6'b001000, 6'b000000, 5'd0,  1'b1, 1'b0, 1'b1, 5'b00000, 12'b0000_000_00000});
    vq.push_back('{"addi_stl",  6'b001000, 6'b000000, 5'd0,  1'b1, 1'b1, 1'b0, 5'b00001, 12'b0000_000_00000});

    // Reset state, including stall_d following stall_in during reset
    #1 rst = 1'b1;
    #2 check("reset_all", 32'(all_obs), 32'd0);
    stall_in = 1'b1;
    #1 check("reset_stall", 32'(stall_d), 32'd1);
    stall_in = 1'b0;
    #3 rst = 1'b0;
    tick();

    foreach (vq[i]) begin
      drive(vq[i].op, vq[i].funct, vq[i].shamt, vq[i].valid, vq[i].stall, vq[i].flush);
      #1 check({vq[i].name, "_dec"}, 32'(dec_obs), 32'(vq[i].exp_dec));
      tick();
      check({vq[i].name, "_e"}, 32'(e_obs), 32'(vq[i].exp_e));
    end

    // add flows through M then W
    drive(6'b000000, 6'b100000, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(6'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("add_flow_e", 32'(e_obs), 32'(12'b1010_010_00000));
    tick();
    check("add_flow_m", 32'(mw_obs), 32'(5'b10000));
    tick();
    check("add_flow_w", 32'(mw_obs), 32'(5'b00010));
    tick();

    // lw then sw: result_src in M for lw, mem_write one cycle later
    drive(6'b100011, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    #1 check("lw_imm", 32'(imm_src_d), 32'd0);
    tick();
    drive(6'b101011, 6'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    #1 check("sw_imm", 32'(imm_src_d), 32'd1);
    tick();
    drive(6'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lw_m", 32'(mw_obs), 32'(5'b10100));
    tick();
    check("sw_m_lw_w", 32'(mw_obs), 32'(5'b01011));
    tick();
    tick();

    // mult with MUL_LAT=4: 3 busy/stall cycles, E held even under flush, M gets bubbles
    drive(6'b000000, 6'b011000, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(6'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      // {busy, stall_d, opt_e, reg_write_e, reg_write_m}
      check($sformatf("mul_busy_c%0d", c),
            32'({mul_busy_e, stall_d, opt_e, reg_write_e, reg_write_m}), 32'(5'b11110));
      flush_e = (c == 1);
      tick();
    end
    flush_e = 1'b0;
    check("mul_c3", 32'({mul_busy_e, stall_d, opt_e, reg_write_e, reg_write_m}), 32'(5'b00110));
    check("mul_c3_alu", 32'(alu_control_e), 32'(3'b010));
    tick();
    check("mul_c4", 32'({mul_busy_e, stall_d, opt_e, reg_write_e, reg_write_m}), 32'(5'b00001));
    tick();
    tick();

    // reset asserted in BUSY cycle 2 clears everything asynchronously
    drive(6'b000000, 6'b011000, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(6'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("pre_rst_busy", 32'(mul_busy_e), 32'd1);
    #2 rst = 1'b1;
    #1 check("mid_busy_rst", 32'(all_obs), 32'd0);
    #2 rst = 1'b0;
    tick();
    check("post_rst_idle", 32'({mul_busy_e, stall_d}), 32'd0);
    drive(6'b000000, 6'b100000, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    drive(6'd0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("post_rst_add_e", 32'(e_obs), 32'(12'b1010_010_00010));
    tick();
    tick();
    check("post_rst_add_w", 32'(mw_obs), 32'(5'b00010));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
